data_mem_lsu: RTL and testbench

//  Parametrised byte-addressable data memory with RV32 load/store semantics.

---
 rtl/data_mem_lsu_pkg.sv | 31 +++
 rtl/data_mem_lsu_bank.sv | 29 ++
 rtl/data_mem_lsu.sv | 159 +++++++++++++++
 tb/tb_data_mem_lsu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data memory load/store unit:
// RV32 func3 encodings for loads and stores, FSM state type,
// and a helper that classifies a func3 as legal for a given direction.
package data_mem_lsu_pkg;

  // Load func3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store func3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } lsu_state_e;

  // True when func3 names a real load (we=0) or store (we=1).
  function automatic logic func3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/data_mem_lsu_bank.sv
// Four independent byte-wide arrays forming one 32-bit word per entry.
// Write: synchronous, per-lane enable. Read: combinational, zero latency.
// No backpressure; the caller owns all arbitration between clear and stores.
module dmem_byte_bank #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    // Lane write: only this lane's byte of wdata, only when its enable is set
    always_ff @(posedge clk) begin
      if (we[l]) begin
        mem[waddr] <= wdata[8*l +: 8];
      end
    end

    assign rdata[8*l +: 8] = mem[raddr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with RV32 load/store semantics and a post-reset clear sequencer.
// Latency: one cycle; response is registered and pulses the cycle after the accepting edge.
// Backpressure: req_ready low during reset and clear only; responses cannot be stalled.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DEPTH_WORDS    = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  lsu_state_e       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_fault_q, rsp_fault_d;

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        byte_off;
  logic              accept;
  logic              fault;
  logic              misalign;
  logic              out_of_range;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [3:0]        bank_we;
  logic [AW-1:0]     bank_waddr;
  logic [31:0]       bank_wdata;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign byte_off = req_addr[1:0];

  // Reset overrides state so the handshake is closed for the whole reset window
  assign req_ready = (state_q == ST_READY) && !reset;
  assign busy      = (state_q == ST_CLEAR) || reset;
  assign accept    = req_valid && req_ready;

  // Clear sequencer: walk ptr from 0 to DEPTH_WORDS-1, then open for requests
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Fault classification and store lane steering from func3 size bits
  always_comb begin
    misalign = 1'b0;
    st_be    = 4'b1111;
    st_data  = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << byte_off;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misalign = req_addr[0];
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{req_wdata[15:0]}};
      end
      default: misalign = (byte_off != 2'b00);
    endcase
    out_of_range = 32'(word_idx) >= DEPTH_WORDS;
    fault        = misalign || out_of_range || !func3_legal(req_we, req_func3);
  end

  // Bank port: clear owns the write port while sequencing, otherwise accepted good stores
  always_comb begin
    bank_we    = 4'b0000;
    bank_waddr = word_idx[AW-1:0];
    bank_wdata = st_data;
    if (state_q == ST_CLEAR && !reset) begin
      bank_we    = 4'b1111;
      bank_waddr = ptr_q;
      bank_wdata = '0;
    end else if (accept && req_we && !fault) begin
      bank_we = st_be;
    end
  end

  dmem_byte_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (word_idx[AW-1:0]),
    .rdata (rd_word)
  );

  // Load extraction and extension, then the next response register contents
  always_comb begin
    ld_byte = rd_word[{byte_off, 3'b000} +: 8];
    ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_func3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LW:      ld_data = rd_word;
      LBU:     ld_data = {24'h0, ld_byte};
      LHU:     ld_data = {16'h0, ld_half};
      default: ld_data = '0;
    endcase
    rsp_valid_d = accept;
    rsp_fault_d = accept && fault;
    rsp_rdata_d = (accept && !req_we && !fault) ? ld_data : 32'h0;
  end

  // State, clear pointer and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench: two instances (256 and 200 words) share one request stream.
// A byte-array model predicts each accepted response; a negedge monitor checks them.
// Directed scenarios first, then randomized traffic.
module tb_data_mem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;

  logic        ready_a, rsp_valid_a, rsp_fault_a, busy_a;
  logic [31:0] rsp_rdata_a;
  logic        ready_b, rsp_valid_b, rsp_fault_b, busy_b;
  logic [31:0] rsp_rdata_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_acc [2];
  int n_rsp [2];

  logic [7:0] mem [2][1024];
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_lsu #(.ADDR_W(10), .DEPTH_WORDS(256), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_fault(rsp_fault_a), .busy(busy_a)
  );

  data_mem_lsu #(.ADDR_W(10), .DEPTH_WORDS(200), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_fault(rsp_fault_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: memory as bytes, access = size bytes starting at addr
  task automatic model_req(input int inst, input logic we, input logic [2:0] f3,
                           input logic [9:0] addr, input logic [31:0] wd, output exp_t e);
    int   depth;
    int   size;
    bit   legal;
    logic [31:0] w;
    depth = (inst == 0) ? 256 : 200;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    e.rdata = 32'h0;
    e.due   = 0;
    e.fault = !legal || (int'(addr) % size != 0) || (int'(addr) / 4 >= depth);
    if (!e.fault) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem[inst][int'(addr) + i] = wd[8*i +: 8];
      end else begin
        w = 32'h0;
        for (int i = 0; i < size; i++) w[8*i +: 8] = mem[inst][int'(addr) + i];
        if (!f3[2] && size < 4 && w[8*size-1]) begin
          for (int i = 8*size; i < 32; i++) w[i] = 1'b1;
        end
        e.rdata = w;
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++) mem[k][i] = 8'h00;
  endtask

  // Present one request (or an idle cycle) at negedge; log it if the DUT will accept
  task automatic issue(input logic v, input logic we, input logic [2:0] f3,
                       input logic [9:0] addr, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    req_valid = v; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    if (v && ready_a) begin
      model_req(0, we, f3, addr, wd, e);
      e.due = cyc + 1;
      q_a.push_back(e);
      n_acc[0]++;
    end
    if (v && ready_b) begin
      model_req(1, we, f3, addr, wd, e);
      e.due = cyc + 1;
      q_b.push_back(e);
      n_acc[1]++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 3'd0, 10'h0, 32'h0);
  endtask

  task automatic mon_one(input int inst, input logic vld, input logic [31:0] rd, input logic flt);
    exp_t e;
    bit   have;
    if (vld === 1'b1) n_rsp[inst]++;
    if (inst == 0) have = (q_a.size() > 0) && (q_a[0].due == cyc);
    else           have = (q_b.size() > 0) && (q_b[0].due == cyc);
    checks++;
    if (have) begin
      if (inst == 0) e = q_a.pop_front();
      else           e = q_b.pop_front();
      if (vld !== 1'b1 || rd !== e.rdata || flt !== e.fault) begin
        failures++;
        $display("FAIL rsp inst=%0d got v=%b d=%h f=%b want v=1 d=%h f=%b t=%0t",
                 inst, vld, rd, flt, e.rdata, e.fault, $time);
      end
    end else if (vld !== 1'b0 || rd !== 32'h0 || flt !== 1'b0) begin
      failures++;
      $display("FAIL idle_rsp inst=%0d got v=%b d=%h f=%b want v=0 d=0 f=0 t=%0t",
               inst, vld, rd, flt, $time);
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, rsp_valid_a, rsp_rdata_a, rsp_fault_a);
    mon_one(1, rsp_valid_b, rsp_rdata_b, rsp_fault_b);
  end

  // Called on the negedge where reset was dropped; counts busy cycles of each instance
  task automatic wait_clear(input string tag);
    int ca = 0;
    int cb = 0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (busy_a === ready_a || busy_b === ready_b) begin
        failures++;
        $display("FAIL %s_ready_vs_busy busy_a=%b ready_a=%b busy_b=%b ready_b=%b", tag, busy_a, ready_a, busy_b, ready_b);
      end
      if (!busy_a && !busy_b) break;
      @(negedge clk);
    end
    check({tag, "_busy_cycles_a"}, ca, 256);
    check({tag, "_busy_cycles_b"}, cb, 200);
    check({tag, "_ready_a"}, {31'h0, ready_a}, 1);
    check({tag, "_ready_b"}, {31'h0, ready_b}, 1);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    n_acc[0] = 0; n_acc[1] = 0; n_rsp[0] = 0; n_rsp[1] = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = 10'h0; req_wdata = 32'h0;

    // Reset window: handshake closed, busy asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_ready_a", {31'h0, ready_a}, 0);
      check("rst_busy_a",  {31'h0, busy_a},  1);
      check("rst_ready_b", {31'h0, ready_b}, 0);
      check("rst_busy_b",  {31'h0, busy_b},  1);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_clear("init");

    // Cleared top word; in the 200-word instance it is out of range
    issue(1, 0, 3'b010, 10'h3FC, 32'h0);
    issue(1, 0, 3'b010, 10'h320, 32'h0);
    issue(1, 0, 3'b010, 10'h31C, 32'h0);

    // Store then back-to-back extending loads
    issue(1, 1, 3'b010, 10'h010, 32'h8000_0081);
    issue(1, 0, 3'b010, 10'h010, 32'h0);
    issue(1, 0, 3'b000, 10'h010, 32'h0);
    issue(1, 0, 3'b100, 10'h010, 32'h0);
    issue(1, 0, 3'b001, 10'h010, 32'h0);
    issue(1, 0, 3'b000, 10'h013, 32'h0);
    issue(1, 0, 3'b101, 10'h012, 32'h0);
    issue(1, 0, 3'b001, 10'h012, 32'h0);

    // Lane steering into a known word
    issue(1, 1, 3'b010, 10'h020, 32'h1122_3344);
    issue(1, 1, 3'b000, 10'h021, 32'hFFFF_FFAB);
    issue(1, 0, 3'b010, 10'h020, 32'h0);
    issue(1, 1, 3'b001, 10'h022, 32'h1234_BEEF);
    issue(1, 0, 3'b010, 10'h020, 32'h0);

    // Faults leave memory untouched
    issue(1, 1, 3'b010, 10'h004, 32'hCAFE_F00D);
    issue(1, 0, 3'b010, 10'h006, 32'h0);
    issue(1, 1, 3'b001, 10'h003, 32'hFFFF_FFFF);
    issue(1, 1, 3'b010, 10'h005, 32'hFFFF_FFFF);
    issue(1, 0, 3'b011, 10'h004, 32'h0);
    issue(1, 1, 3'b100, 10'h004, 32'hFFFF_FFFF);
    issue(1, 1, 3'b010, 10'h340, 32'h5555_AAAA);
    issue(1, 0, 3'b010, 10'h004, 32'h0);
    issue(1, 0, 3'b010, 10'h340, 32'h0);
    idle(2);

    // 20 consecutive accepted requests: 20 pulses, in order
    r0 = n_rsp[0];
    for (int i = 0; i < 20; i++)
      issue(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
            10'($urandom_range(0, 63)) & 10'h3FC, $urandom);
    idle(2);
    check("burst20_pulses", n_rsp[0] - r0, 20);

    // Randomized traffic with gaps
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3;
      logic [9:0] a;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        r0 = $urandom_range(0, 4);
        f3 = (r0 == 3) ? 3'd4 : (r0 == 4) ? 3'd5 : 3'(r0);
      end
      if ($urandom_range(0, 4) == 0) a = 10'($urandom_range(0, 1023));
      else a = 10'($urandom_range(0, 47));
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), f3, a, $urandom);
    end
    idle(2);

    // Reset mid-clear restarts the sequence; a store in the reset cycle is dropped
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; model_clear();
    for (int i = 0; i < 100; i++) @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
    req_addr = 10'h010; req_wdata = 32'hDEAD_BEEF;
    #1;
    check("rst_cycle_ready_a", {31'h0, ready_a}, 0);
    check("rst_cycle_busy_a",  {31'h0, busy_a},  1);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    model_clear();
    wait_clear("midclr");
    issue(1, 0, 3'b010, 10'h010, 32'h0);
    issue(1, 0, 3'b010, 10'h020, 32'h0);
    idle(3);

    check("queue_empty_a", q_a.size(), 0);
    check("queue_empty_b", q_b.size(), 0);
    check("pulses_vs_accepts_a", n_rsp[0], n_acc[0]);
    check("pulses_vs_accepts_b", n_rsp[1], n_acc[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
